// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer
// Streams a raster frame through two line buffers and a 3x3 window. For every
// interior pixel it packs the eight neighbours into a 32-bit operand pair,
// performs one multicycle handshake with the convolution unit, and emits the
// clamped 8-bit gradient magnitude. Border pixels produce no output.
//
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   cfg_start_i              one-cycle pulse that starts a frame (IDLE only)
//   pix_valid_i/pix_ready_o  input pixel handshake, pix_data_i in raster order
//   conv_clk_en_o            clock enable for the convolution unit (busy)
//   conv_start_o             one-cycle operand-valid pulse
//   conv_dataa_o/datab_o     packed neighbours {d,c,b,a} / {i,h,g,f}
//   conv_done_i/result_i     convolution completion and unsigned magnitude
//   out_valid_o/out_ready_o  output handshake, out_data_o clamped magnitude
//   busy_o                   frame in progress (any state but IDLE)
//   frame_done_o             one-cycle pulse after the last output is taken
//   err_o                    sticky convolution timeout flag
module sobel_frame_sequencer #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cfg_start_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [7:0]  pix_data_i,
    output logic        conv_clk_en_o,
    output logic        conv_start_o,
    output logic [31:0] conv_dataa_o,
    output logic [31:0] conv_datab_o,
    input  logic        conv_done_i,
    input  logic [31:0] conv_result_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    // Row counter steps one past the last row after the final pixel.
    localparam int RW = $clog2(IMG_H + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          last_q, last_d;
    logic [7:0]    out_data_q, out_data_d;
    logic [31:0]   dataa_q, dataa_d;
    logic [31:0]   datab_q, datab_d;

    // Line buffers and the two most recent window columns; their contents are
    // overwritten by rows 0-1 (and columns 0-1 of each row) before use.
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb1_q [IMG_W];
    logic [23:0]   win_a_q;   // oldest column {top, mid, bot}
    logic [23:0]   win_b_q;   // middle column {top, mid, bot}
    logic [23:0]   new_col_s; // column arriving with this pixel
    logic          pix_hs_s;

    assign new_col_s = {lb0_q[col_q], lb1_q[col_q], pix_data_i};
    assign pix_hs_s  = (state_q == S_ACCEPT) && pix_valid_i;

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        dataa_d    = dataa_q;
        datab_d    = datab_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    state_d = S_ACCEPT;
                    row_d   = {RW{1'b0}};
                    col_d   = {CW{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (pix_valid_i) begin
                    // Window after the shift is {win_a, win_b, new}:
                    // a b c = tops, d f = mids of outer columns, g h i = bottoms.
                    dataa_d = {win_a_q[15:8], new_col_s[23:16], win_b_q[23:16], win_a_q[23:16]};
                    datab_d = {new_col_s[7:0], win_b_q[7:0], win_a_q[7:0], new_col_s[15:8]};
                    last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    if (col_q == COL_LAST) begin
                        col_d = {CW{1'b0}};
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_ISSUE: begin
                cnt_d   = {TW{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the timeout cycle still wins.
                if (conv_done_i) begin
                    out_data_d = (conv_result_i > 32'd255) ? 8'd255 : conv_result_i[7:0];
                    state_d    = S_EMIT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    out_data_d = 8'd0;
                    state_d    = S_EMIT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    state_d = last_q ? S_DONE : S_ACCEPT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            row_q      <= {RW{1'b0}};
            col_q      <= {CW{1'b0}};
            cnt_q      <= {TW{1'b0}};
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            out_data_q <= 8'd0;
            dataa_q    <= 32'd0;
            datab_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            dataa_q    <= dataa_d;
            datab_q    <= datab_d;
        end
    end

    // Line-buffer rotation and window shift on every accepted pixel.
    always_ff @(posedge clk_i) begin
        if (pix_hs_s) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= pix_data_i;
            win_a_q      <= win_b_q;
            win_b_q      <= new_col_s;
        end
    end

    assign pix_ready_o   = (state_q == S_ACCEPT);
    assign conv_start_o  = (state_q == S_ISSUE);
    assign out_valid_o   = (state_q == S_EMIT);
    assign frame_done_o  = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign conv_clk_en_o = (state_q != S_IDLE);
    assign conv_dataa_o  = dataa_q;
    assign conv_datab_o  = datab_q;
    assign out_data_o    = out_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer. Two instances share the clock:
// A is 3x3 with a short timeout, B is 5x4. Expected operands and outputs are
// queued as stimulus is issued; monitor processes compare on DUT events.
module tb_sobel_frame_sequencer;
    logic clk;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // Instance A signals
    logic        a_reset, a_cfg_start, a_pix_valid, a_pix_ready;
    logic [7:0]  a_pix_data;
    logic        a_conv_clk_en, a_conv_start;
    logic [31:0] a_dataa, a_datab;
    logic        a_done_resp, a_done_stale;
    logic [31:0] a_conv_result;
    logic        a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;
    logic        a_busy, a_frame_done, a_err;
    int          a_mode;   // 0: result 42, 1: sobel model, 2: never respond
    int          a_viol = 0;

    // Instance B signals
    logic        b_reset, b_cfg_start, b_pix_valid, b_pix_ready;
    logic [7:0]  b_pix_data;
    logic        b_conv_clk_en, b_conv_start;
    logic [31:0] b_dataa, b_datab;
    logic        b_conv_done;
    logic [31:0] b_conv_result;
    logic        b_out_valid, b_out_ready;
    logic [7:0]  b_out_data;
    logic        b_busy, b_frame_done, b_err;
    logic        b_stall_arm, b_stall_done;
    int          b_viol = 0;
    int          b_cs_cnt = 0;
    int          b_fd_cnt = 0;

    logic [63:0] exp_a_ops[$];
    logic [7:0]  exp_a_out[$];
    logic [7:0]  exp_b_out[$];

    sobel_frame_sequencer #(.IMG_W(3), .IMG_H(3), .TIMEOUT(8)) u_a (
        .clk_i(clk), .reset_i(a_reset), .cfg_start_i(a_cfg_start),
        .pix_valid_i(a_pix_valid), .pix_ready_o(a_pix_ready), .pix_data_i(a_pix_data),
        .conv_clk_en_o(a_conv_clk_en), .conv_start_o(a_conv_start),
        .conv_dataa_o(a_dataa), .conv_datab_o(a_datab),
        .conv_done_i(a_done_resp | a_done_stale), .conv_result_i(a_conv_result),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .busy_o(a_busy), .frame_done_o(a_frame_done), .err_o(a_err)
    );

    sobel_frame_sequencer #(.IMG_W(5), .IMG_H(4), .TIMEOUT(255)) u_b (
        .clk_i(clk), .reset_i(b_reset), .cfg_start_i(b_cfg_start),
        .pix_valid_i(b_pix_valid), .pix_ready_o(b_pix_ready), .pix_data_i(b_pix_data),
        .conv_clk_en_o(b_conv_clk_en), .conv_start_o(b_conv_start),
        .conv_dataa_o(b_dataa), .conv_datab_o(b_datab),
        .conv_done_i(b_conv_done), .conv_result_i(b_conv_result),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .busy_o(b_busy), .frame_done_o(b_frame_done), .err_o(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // |Gx| + |Gy| computed from the packed neighbours.
    function automatic logic [31:0] sobel(input logic [31:0] da, input logic [31:0] db);
        int a, b, c, d, f, g, h, i, gx, gy;
        a = int'(da[7:0]);   b = int'(da[15:8]);  c = int'(da[23:16]); d = int'(da[31:24]);
        f = int'(db[7:0]);   g = int'(db[15:8]);  h = int'(db[23:16]); i = int'(db[31:24]);
        gx = (c + 2 * f + i) - (a + 2 * d + g);
        gy = (g + 2 * h + i) - (a + 2 * b + c);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return 32'(gx + gy);
    endfunction

    // Convolution unit model for A: 3-cycle latency, behaviour set by a_mode.
    initial begin : resp_a
        logic [31:0] r;
        a_done_resp = 1'b0;
        a_conv_result = 32'd0;
        forever begin
            @(negedge clk);
            a_done_resp = 1'b0;
            if (a_conv_start && a_mode != 2) begin
                r = (a_mode == 0) ? 32'd42 : sobel(a_dataa, a_datab);
                repeat (3) @(negedge clk);
                a_conv_result = r;
                a_done_resp = 1'b1;
            end
        end
    end

    // Convolution unit model for B: sobel magnitude, 2-cycle latency.
    initial begin : resp_b
        logic [31:0] r;
        b_conv_done = 1'b0;
        b_conv_result = 32'd0;
        forever begin
            @(negedge clk);
            b_conv_done = 1'b0;
            if (b_conv_start) begin
                r = sobel(b_dataa, b_datab);
                repeat (2) @(negedge clk);
                b_conv_result = r;
                b_conv_done = 1'b1;
            end
        end
    end

    // B output consumer: once armed, withholds out_ready for 10 cycles.
    initial begin : ready_b
        b_out_ready = 1'b1;
        b_stall_done = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (b_stall_arm && !b_stall_done && b_out_valid) begin
                b_out_ready = 1'b0;
                repeat (10) begin @(posedge clk); #2; end
                b_out_ready = 1'b1;
                b_stall_done = 1'b1;
            end
        end
    end

    // Monitor A: operands on conv_start, data on output, frame_done timing.
    initial begin : mon_a
        int last_hs;
        last_hs = -10;
        forever begin
            @(negedge clk);
            if (a_pix_ready && a_out_valid) a_viol++;
            if (a_conv_start) begin
                if (exp_a_ops.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_conv_start_extra: got dataa=%h datab=%h, expected no conv_start", a_dataa, a_datab);
                end else begin
                    check("a_operands", {a_dataa, a_datab}, exp_a_ops.pop_front());
                end
            end
            if (a_out_valid) begin
                if (exp_a_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_out_extra: got data %0h, expected no output", a_out_data);
                end else if (a_out_ready) begin
                    check("a_out_data", 64'(a_out_data), 64'(exp_a_out.pop_front()));
                    last_hs = cyc;
                end else begin
                    check("a_out_hold", 64'(a_out_data), 64'(exp_a_out[0]));
                end
            end
            if (a_frame_done) check("a_frame_done_timing", 64'(cyc), 64'(last_hs + 1));
        end
    end

    // Monitor B: output data incl. hold during stall, pulse counts, timing.
    initial begin : mon_b
        int last_hs;
        last_hs = -10;
        forever begin
            @(negedge clk);
            if (b_pix_ready && b_out_valid) b_viol++;
            if (b_conv_start) b_cs_cnt++;
            if (b_out_valid) begin
                if (exp_b_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_out_extra: got data %0h, expected no output", b_out_data);
                end else if (b_out_ready) begin
                    check("b_out_data", 64'(b_out_data), 64'(exp_b_out.pop_front()));
                    last_hs = cyc;
                end else begin
                    check("b_out_hold", 64'(b_out_data), 64'(exp_b_out[0]));
                end
            end
            if (b_frame_done) begin
                b_fd_cnt++;
                check("b_frame_done_timing", 64'(cyc), 64'(last_hs + 1));
            end
        end
    end

    task automatic send_a(input logic [7:0] d);
        int n;
        n = 0;
        a_pix_valid = 1'b1;
        a_pix_data = d;
        while (!a_pix_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL a_pix_ready_timeout: got no pix_ready in %0d cycles, expected handshake", n);
        end
        @(negedge clk);
        a_pix_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n;
        n = 0;
        b_pix_valid = 1'b1;
        b_pix_data = d;
        while (!b_pix_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL b_pix_ready_timeout: got no pix_ready in %0d cycles, expected handshake", n);
        end
        @(negedge clk);
        b_pix_valid = 1'b0;
    endtask

    task automatic pulse_start_a();
        a_cfg_start = 1'b1;
        @(negedge clk);
        a_cfg_start = 1'b0;
    endtask

    task automatic pulse_start_b();
        b_cfg_start = 1'b1;
        @(negedge clk);
        b_cfg_start = 1'b0;
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        while (!a_frame_done && n < 2000) begin @(negedge clk); n++; end
        check("a_frame_done_seen", 64'(a_frame_done), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_done_b();
        int n;
        n = 0;
        while (!b_frame_done && n < 2000) begin @(negedge clk); n++; end
        check("b_frame_done_seen", 64'(b_frame_done), 64'd1);
        @(negedge clk);
    endtask

    initial begin : stim
        int n, cs0, fd0;
        a_reset = 1'b1; a_cfg_start = 1'b0; a_pix_valid = 1'b0; a_pix_data = 8'd0;
        a_out_ready = 1'b1; a_done_stale = 1'b0; a_mode = 0;
        b_reset = 1'b1; b_cfg_start = 1'b0; b_pix_valid = 1'b0; b_pix_data = 8'd0;
        b_stall_arm = 1'b0;
        repeat (3) @(negedge clk);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        check("rst_pix_ready", 64'(a_pix_ready), 64'd0);
        check("rst_conv_start", 64'(a_conv_start), 64'd0);
        check("rst_conv_clk_en", 64'(a_conv_clk_en), 64'd0);
        check("rst_dataa", 64'(a_dataa), 64'd0);
        check("rst_datab", 64'(a_datab), 64'd0);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_frame_done", 64'(a_frame_done), 64'd0);
        check("rst_err", 64'(a_err), 64'd0);
        check("rst_b_busy", 64'(b_busy), 64'd0);

        // A: 3x3 frame 1..9, model returns 42
        pulse_start_a();
        check("a_busy_in_frame", 64'(a_busy), 64'd1);
        check("a_clk_en_in_frame", 64'(a_conv_clk_en), 64'd1);
        exp_a_ops.push_back({32'h04030201, 32'h09080706});
        exp_a_out.push_back(8'd42);
        for (int k = 1; k <= 9; k++) send_a(8'(k));
        check("a_conv_start_latency", 64'(a_conv_start), 64'd1);
        wait_done_a();
        check("a_idle_after_done", 64'(a_busy), 64'd0);

        // A: convolution never completes -> timeout after 8 WAIT cycles
        a_mode = 2;
        pulse_start_a();
        exp_a_ops.push_back({32'h281E140A, 32'h5A50463C});
        exp_a_out.push_back(8'd0);
        for (int k = 1; k <= 9; k++) send_a(8'(10 * k));
        n = 0;
        while (!a_out_valid && n < 50) begin @(negedge clk); n++; end
        check("a_timeout_cycles", 64'(n), 64'd9);
        check("a_err_on_timeout", 64'(a_err), 64'd1);
        wait_done_a();
        check("a_err_sticky", 64'(a_err), 64'd1);

        // A: next cfg_start clears err; reset while waiting on the convolution
        pulse_start_a();
        check("a_err_cleared", 64'(a_err), 64'd0);
        exp_a_ops.push_back({32'h04030201, 32'h09080706});
        for (int k = 1; k <= 9; k++) send_a(8'(k));
        repeat (3) @(negedge clk);
        check("a_busy_in_wait", 64'(a_busy), 64'd1);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        check("a_reset_mid_idle", 64'(a_busy), 64'd0);
        check("a_reset_mid_dataa", 64'(a_dataa), 64'd0);
        a_done_stale = 1'b1;
        @(negedge clk);
        a_done_stale = 1'b0;
        a_mode = 0;
        pulse_start_a();
        a_done_stale = 1'b1;
        @(negedge clk);
        a_done_stale = 1'b0;
        check("a_stale_done_ignored", 64'(a_pix_ready), 64'd1);
        exp_a_ops.push_back({32'h06070809, 32'h01020304});
        exp_a_out.push_back(8'd42);
        for (int k = 1; k <= 9; k++) send_a(8'(10 - k));
        wait_done_a();

        // B: flat 50 image with one 10-cycle output stall
        b_stall_arm = 1'b1;
        cs0 = b_cs_cnt;
        fd0 = b_fd_cnt;
        pulse_start_b();
        for (int k = 0; k < 6; k++) exp_b_out.push_back(8'd0);
        for (int k = 0; k < 20; k++) send_b(8'd50);
        wait_done_b();
        repeat (3) @(negedge clk);
        check("b_flat_conv_starts", 64'(b_cs_cnt - cs0), 64'd6);
        check("b_flat_frame_done_count", 64'(b_fd_cnt - fd0), 64'd1);
        check("b_flat_outputs_pending", 64'(exp_b_out.size()), 64'd0);
        check("b_stall_applied", 64'(b_stall_done), 64'd1);

        // B: rows 0,0,255,255 -> 1020 clamps to 255; cfg_start mid-frame ignored
        cs0 = b_cs_cnt;
        fd0 = b_fd_cnt;
        pulse_start_b();
        for (int k = 0; k < 6; k++) exp_b_out.push_back(8'd255);
        for (int k = 0; k < 20; k++) begin
            send_b((k / 5 >= 2) ? 8'd255 : 8'd0);
            if (k == 6) pulse_start_b();
        end
        wait_done_b();
        repeat (3) @(negedge clk);
        check("b_clamp_conv_starts", 64'(b_cs_cnt - cs0), 64'd6);
        check("b_clamp_frame_done_count", 64'(b_fd_cnt - fd0), 64'd1);
        check("b_clamp_outputs_pending", 64'(exp_b_out.size()), 64'd0);

        check("a_outputs_pending", 64'(exp_a_out.size()), 64'd0);
        check("a_operands_pending", 64'(exp_a_ops.size()), 64'd0);
        check("a_ready_valid_overlap", 64'(a_viol), 64'd0);
        check("b_ready_valid_overlap", 64'(b_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
